// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: ALU op codes, B-operand select codes, multiplier FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ex_pkg;

  // ALUctr_EX encodings; codes 12-15 produce a zero result
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;
  localparam logic [3:0] ALU_MUL   = 4'd11;

  // ALUBSrc_EX encodings
  localparam logic [1:0] BSRC_BUS  = 2'b00;
  localparam logic [1:0] BSRC_IMM  = 2'b01;
  localparam logic [1:0] BSRC_FOUR = 2'b10;
  localparam logic [1:0] BSRC_ZERO = 2'b11;

  // Return-address increment used by jump-and-link style ops
  localparam logic [31:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs, EX/MEM register outputs and PC-control outputs of the execute stage.
// Latency: n/a (signal bundle only).
// Backpressure: stall_o asks the upstream stages to hold their contents.
interface ex_stage_if;
  // ID/EX
  logic [31:0] busA_EX;
  logic [31:0] busB_EX;
  logic [31:0] PC_EX;
  logic [31:0] imm_EX;
  logic [5:0]  Rd_EX;
  logic        MemWr_EX;
  logic        Branch_EX;
  logic        Jump_EX;
  logic        MemtoReg_EX;
  logic        RegWr_EX;
  logic        ALUASrc_EX;
  logic [1:0]  ALUBSrc_EX;
  logic [3:0]  ALUctr_EX;
  // EX/MEM
  logic [31:0] ALUout_MEM;
  logic [31:0] storeData_MEM;
  logic [5:0]  Rd_MEM;
  logic        MemWr_MEM;
  logic        MemtoReg_MEM;
  logic        RegWr_MEM;
  // PC control
  logic        redirect_o;
  logic [31:0] target_o;
  logic        stall_o;

  // Upstream pipeline side: presents ID/EX, observes EX/MEM and PC control
  modport master (
    output busA_EX, busB_EX, PC_EX, imm_EX, Rd_EX, MemWr_EX, Branch_EX, Jump_EX,
           MemtoReg_EX, RegWr_EX, ALUASrc_EX, ALUBSrc_EX, ALUctr_EX,
    input  ALUout_MEM, storeData_MEM, Rd_MEM, MemWr_MEM, MemtoReg_MEM, RegWr_MEM,
           redirect_o, target_o, stall_o
  );

  // Execute stage side
  modport slave (
    input  busA_EX, busB_EX, PC_EX, imm_EX, Rd_EX, MemWr_EX, Branch_EX, Jump_EX,
           MemtoReg_EX, RegWr_EX, ALUASrc_EX, ALUBSrc_EX, ALUctr_EX,
    output ALUout_MEM, storeData_MEM, Rd_MEM, MemWr_MEM, MemtoReg_MEM, RegWr_MEM,
           redirect_o, target_o, stall_o
  );
endinterface

// File: rtl/ex_stage_mul_seq.sv
// Sequential shift-add 32x32 multiplier, low 32 bits of the unsigned product.
// Latency: one edge to load, 32 edges in BUSY, then one cycle in DONE with the product valid.
// Backpressure: none internally; the parent stalls the pipe while start-in-IDLE or busy.
module mul_seq
  import ex_pkg::*;
(
  input  logic        CLK,
  input  logic        Resetn,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  mul_state_e  state, state_nxt;
  logic [31:0] a_q, b_q, prod_q;
  logic [4:0]  cnt_q;

  // State register
  always_ff @(negedge CLK) begin
    if (!Resetn) state <= MUL_IDLE;
    else         state <= state_nxt;
  end

  // Next state: DONE always returns to IDLE so a held MUL is never re-run from DONE
  always_comb begin
    state_nxt = state;
    case (state)
      MUL_IDLE: if (start) state_nxt = MUL_BUSY;
      MUL_BUSY: if (cnt_q == 5'd31) state_nxt = MUL_DONE;
      MUL_DONE: state_nxt = MUL_IDLE;
      default:  state_nxt = MUL_IDLE;
    endcase
  end

  // Operand latch and one partial product per BUSY edge
  always_ff @(negedge CLK) begin
    if (!Resetn) begin
      a_q    <= '0;
      b_q    <= '0;
      prod_q <= '0;
      cnt_q  <= '0;
    end else begin
      case (state)
        MUL_IDLE: begin
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            prod_q <= '0;
            cnt_q  <= '0;
          end
        end
        MUL_BUSY: begin
          if (b_q[cnt_q]) prod_q <= prod_q + (a_q << cnt_q);
          cnt_q <= cnt_q + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state == MUL_BUSY);
  assign done    = (state == MUL_DONE);
  assign product = prod_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand muxes, ALU, branch/jump resolution and EX/MEM register.
// Latency: one edge for single-cycle ops; 34 cycles for MUL (33 stalled + 1 DONE).
// Backpressure: stall_o holds IF/ID/ID-EX while a MUL is pending; EX/MEM gets bubbles meanwhile.
module ex_stage
  import ex_pkg::*;
(
  input logic        CLK,
  input logic        Resetn,
  ex_stage_if.slave  bus
);

  logic [31:0] op_a, op_b, alu_res, mul_prod;
  logic        is_mul, mul_busy, mul_done, mul_idle, stall;

  assign is_mul   = (bus.ALUctr_EX == ALU_MUL);
  assign mul_idle = !mul_busy && !mul_done;
  assign stall    = (mul_idle && is_mul) || mul_busy;

  mul_seq u_mul (
    .CLK     (CLK),
    .Resetn  (Resetn),
    .start   (is_mul),
    .a       (op_a),
    .b       (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Operand selection
  always_comb begin
    op_a = bus.ALUASrc_EX ? bus.PC_EX : bus.busA_EX;
    case (bus.ALUBSrc_EX)
      BSRC_BUS:  op_b = bus.busB_EX;
      BSRC_IMM:  op_b = bus.imm_EX;
      BSRC_FOUR: op_b = PC_INC;
      default:   op_b = 32'd0;
    endcase
  end

  // ALU; MUL reports the sequencer product, which is only meaningful in DONE
  always_comb begin
    alu_res = 32'd0;
    case (bus.ALUctr_EX)
      ALU_ADD:   alu_res = op_a + op_b;
      ALU_SUB:   alu_res = op_a - op_b;
      ALU_SLL:   alu_res = op_a << op_b[4:0];
      ALU_SLT:   alu_res = {31'd0, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU:  alu_res = {31'd0, (op_a < op_b)};
      ALU_XOR:   alu_res = op_a ^ op_b;
      ALU_SRL:   alu_res = op_a >> op_b[4:0];
      ALU_SRA:   alu_res = $unsigned($signed(op_a) >>> op_b[4:0]);
      ALU_OR:    alu_res = op_a | op_b;
      ALU_AND:   alu_res = op_a & op_b;
      ALU_PASSB: alu_res = op_b;
      ALU_MUL:   alu_res = mul_prod;
      default:   alu_res = 32'd0;
    endcase
  end

  // PC control; gating with stall defers a MUL's branch decision to DONE
  always_comb begin
    bus.stall_o    = stall;
    bus.target_o   = bus.PC_EX + bus.imm_EX;
    bus.redirect_o = ((bus.Branch_EX && (alu_res == 32'd0)) || bus.Jump_EX) && !stall;
  end

  // EX/MEM register: bubble while stalled
  always_ff @(negedge CLK) begin
    if (!Resetn || stall) begin
      bus.ALUout_MEM    <= '0;
      bus.storeData_MEM <= '0;
      bus.Rd_MEM        <= '0;
      bus.MemWr_MEM     <= 1'b0;
      bus.MemtoReg_MEM  <= 1'b0;
      bus.RegWr_MEM     <= 1'b0;
    end else begin
      bus.ALUout_MEM    <= alu_res;
      bus.storeData_MEM <= bus.busB_EX;
      bus.Rd_MEM        <= bus.Rd_EX;
      bus.MemWr_MEM     <= bus.MemWr_EX;
      bus.MemtoReg_MEM  <= bus.MemtoReg_EX;
      bus.RegWr_MEM     <= bus.RegWr_EX;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, branch/jump, sequential MUL stall and reset abort.
// Latency: n/a.
// Backpressure: observes stall_o for MUL duration.
module tb_ex_stage;
  import ex_pkg::*;

  logic CLK = 1'b0;
  logic Resetn;
  int   tests = 0;
  int   fails = 0;
  int   ncyc;

  always #5 CLK = ~CLK;

  ex_stage_if ex_if ();

  ex_stage dut (
    .CLK    (CLK),
    .Resetn (Resetn),
    .bus    (ex_if)
  );

  // Advance to just after the next active (falling) edge
  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    ex_if.busA_EX = '0; ex_if.busB_EX = '0; ex_if.PC_EX = '0; ex_if.imm_EX = '0;
    ex_if.Rd_EX = '0; ex_if.MemWr_EX = 0; ex_if.Branch_EX = 0; ex_if.Jump_EX = 0;
    ex_if.MemtoReg_EX = 0; ex_if.RegWr_EX = 0; ex_if.ALUASrc_EX = 0;
    ex_if.ALUBSrc_EX = BSRC_BUS; ex_if.ALUctr_EX = ALU_ADD;
  endtask

  // Register-operand op, one edge, check ALUout_MEM
  task automatic alu_rr(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    ex_if.ALUctr_EX = op; ex_if.busA_EX = a; ex_if.busB_EX = b;
    ex_if.ALUASrc_EX = 0; ex_if.ALUBSrc_EX = BSRC_BUS;
    tick();
    chk(tag, ex_if.ALUout_MEM, exp);
  endtask

  // Count stalled cycles of a MUL, checking bubbles and gated redirect each cycle
  task automatic mul_wait(output int n);
    n = 0;
    while (ex_if.stall_o && n < 40) begin
      n++;
      chk("mul_redirect_gated", {31'd0, ex_if.redirect_o}, 32'd0);
      tick();
      chk("mul_bubble_aluout", ex_if.ALUout_MEM, 32'd0);
      chk("mul_bubble_regwr", {31'd0, ex_if.RegWr_MEM}, 32'd0);
    end
  endtask

  initial begin
    clr();
    Resetn = 0;
    tick(); tick();
    chk("rst_aluout", ex_if.ALUout_MEM, 32'd0);
    chk("rst_rd", {26'd0, ex_if.Rd_MEM}, 32'd0);
    chk("rst_regwr", {31'd0, ex_if.RegWr_MEM}, 32'd0);
    chk("rst_stall", {31'd0, ex_if.stall_o}, 32'd0);
    Resetn = 1;

    // ADD with immediate
    ex_if.busA_EX = 5; ex_if.imm_EX = 7; ex_if.ALUBSrc_EX = BSRC_IMM;
    ex_if.RegWr_EX = 1; ex_if.Rd_EX = 6'd3; ex_if.ALUctr_EX = ALU_ADD;
    #1;
    chk("add_redirect", {31'd0, ex_if.redirect_o}, 32'd0);
    tick();
    chk("add_aluout", ex_if.ALUout_MEM, 32'd12);
    chk("add_rd", {26'd0, ex_if.Rd_MEM}, 32'd3);
    chk("add_regwr", {31'd0, ex_if.RegWr_MEM}, 32'd1);

    // SUB branch taken / not taken
    clr();
    ex_if.busA_EX = 9; ex_if.busB_EX = 9; ex_if.Branch_EX = 1;
    ex_if.PC_EX = 32'h100; ex_if.imm_EX = 32'h20; ex_if.ALUctr_EX = ALU_SUB; ex_if.MemWr_EX = 1;
    #1;
    chk("beq_redirect", {31'd0, ex_if.redirect_o}, 32'd1);
    chk("beq_target", ex_if.target_o, 32'h120);
    ex_if.busB_EX = 8;
    #1;
    chk("bne_redirect", {31'd0, ex_if.redirect_o}, 32'd0);
    chk("bne_target", ex_if.target_o, 32'h120);
    tick();
    chk("sub_aluout", ex_if.ALUout_MEM, 32'd1);
    chk("sub_storedata", ex_if.storeData_MEM, 32'd8);
    chk("sub_memwr", {31'd0, ex_if.MemWr_MEM}, 32'd1);

    // Jump with link address PC+4
    clr();
    ex_if.Jump_EX = 1; ex_if.ALUASrc_EX = 1; ex_if.ALUBSrc_EX = BSRC_FOUR;
    ex_if.PC_EX = 32'h40; ex_if.RegWr_EX = 1; ex_if.Rd_EX = 6'd33;
    #1;
    chk("jmp_redirect", {31'd0, ex_if.redirect_o}, 32'd1);
    chk("jmp_target", ex_if.target_o, 32'h40);
    tick();
    chk("jmp_aluout", ex_if.ALUout_MEM, 32'h44);
    chk("jmp_rd", {26'd0, ex_if.Rd_MEM}, 32'd33);

    // Assorted ALU ops
    clr();
    ex_if.RegWr_EX = 1;
    alu_rr("slt",  ALU_SLT,  32'h8000_0000, 32'd1, 32'd1);
    alu_rr("sltu", ALU_SLTU, 32'h8000_0000, 32'd1, 32'd0);
    alu_rr("sra",  ALU_SRA,  32'h8000_0000, 32'd4, 32'hF800_0000);
    alu_rr("srl",  ALU_SRL,  32'h8000_0000, 32'd4, 32'h0800_0000);
    alu_rr("sll_mask", ALU_SLL, 32'd1, 32'h24, 32'h10);
    alu_rr("xor",  ALU_XOR,  32'hF0F0, 32'h0FF0, 32'hFF00);
    alu_rr("and",  ALU_AND,  32'hF0F0, 32'h0FF0, 32'h00F0);
    alu_rr("sub_wrap", ALU_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF);
    alu_rr("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'd2, 32'd1);
    alu_rr("op13_zero", 4'd13, 32'h1234, 32'h5678, 32'd0);
    ex_if.ALUctr_EX = ALU_OR; ex_if.busA_EX = 32'h1234; ex_if.busB_EX = 32'hFFFF;
    ex_if.ALUBSrc_EX = BSRC_ZERO;
    tick();
    chk("or_bzero", ex_if.ALUout_MEM, 32'h1234);
    ex_if.ALUctr_EX = ALU_PASSB; ex_if.imm_EX = 32'hDEAD; ex_if.ALUBSrc_EX = BSRC_IMM;
    tick();
    chk("passb_imm", ex_if.ALUout_MEM, 32'hDEAD);

    // MUL 0xFFFFFFFF x 3
    clr();
    ex_if.busA_EX = 32'hFFFF_FFFF; ex_if.busB_EX = 3; ex_if.ALUctr_EX = ALU_MUL;
    ex_if.RegWr_EX = 1; ex_if.Rd_EX = 6'd5;
    #1;
    mul_wait(ncyc);
    chk("mul1_stall_cycles", ncyc, 32'd33);
    chk("mul1_done_stall", {31'd0, ex_if.stall_o}, 32'd0);
    tick();
    clr();
    chk("mul1_aluout", ex_if.ALUout_MEM, 32'hFFFF_FFFD);
    chk("mul1_regwr", {31'd0, ex_if.RegWr_MEM}, 32'd1);
    chk("mul1_rd", {26'd0, ex_if.Rd_MEM}, 32'd5);

    // Reset while BUSY at count 10
    ex_if.busA_EX = 32'h1234_5678; ex_if.busB_EX = 32'hFFFF; ex_if.ALUctr_EX = ALU_MUL;
    ex_if.RegWr_EX = 1; ex_if.Rd_EX = 6'd7;
    #1;
    chk("mulr_stall_idle", {31'd0, ex_if.stall_o}, 32'd1);
    repeat (11) tick();
    chk("mulr_stall_busy", {31'd0, ex_if.stall_o}, 32'd1);
    Resetn = 0;
    ex_if.ALUctr_EX = ALU_ADD;
    tick();
    chk("mulr_rst_aluout", ex_if.ALUout_MEM, 32'd0);
    chk("mulr_rst_regwr", {31'd0, ex_if.RegWr_MEM}, 32'd0);
    chk("mulr_rst_stall", {31'd0, ex_if.stall_o}, 32'd0);
    // MUL 6x7 with jump: redirect only once DONE
    ex_if.busA_EX = 6; ex_if.busB_EX = 7; ex_if.ALUctr_EX = ALU_MUL; ex_if.Jump_EX = 1;
    ex_if.PC_EX = 32'h200; ex_if.imm_EX = 32'h10;
    tick();
    Resetn = 1;
    #1;
    mul_wait(ncyc);
    chk("mul2_stall_cycles", ncyc, 32'd33);
    chk("mul2_done_redirect", {31'd0, ex_if.redirect_o}, 32'd1);
    chk("mul2_done_target", ex_if.target_o, 32'h210);
    tick();
    chk("mul2_aluout", ex_if.ALUout_MEM, 32'd42);
    chk("mul2_regwr", {31'd0, ex_if.RegWr_MEM}, 32'd1);

    // Back-to-back MUL restarts from IDLE
    ex_if.Jump_EX = 0; ex_if.busA_EX = 2; ex_if.busB_EX = 3;
    #1;
    mul_wait(ncyc);
    chk("mul3_stall_cycles", ncyc, 32'd33);
    tick();
    chk("mul3_aluout", ex_if.ALUout_MEM, 32'd6);
    clr();
    tick();
    chk("final_stall", {31'd0, ex_if.stall_o}, 32'd0);
    chk("final_aluout", ex_if.ALUout_MEM, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have ports: CLK  in  1  single clock; all state updates on negedge CLK.
REQ-002 SHALL have ports: Resetn  in  1  reset, synchronous and active-low, sampled on negedge CLK.
REQ-003 SHALL accept ID/EX inputs: busA_EX 32, busB_EX 32, PC_EX 32, imm_EX 32, Rd_EX 6, MemWr_EX 1, Branch_EX 1, Jump_EX 1, MemtoReg_EX 1, RegWr_EX 1, ALUASrc_EX 1, ALUBSrc_EX 2, ALUctr_EX 4.
REQ-004 SHALL drive EX/MEM register outputs: ALUout_MEM 32, storeData_MEM 32, Rd_MEM 6, MemWr_MEM 1, MemtoReg_MEM 1, RegWr_MEM 1.
REQ-005 SHALL drive combinational outputs: redirect_o 1 (take branch/jump), target_o 32 (new PC), stall_o 1 (hold IF, ID and ID/EX).

Function
REQ-006 SHALL select operand A: ALUASrc_EX=0 -> busA_EX; 1 -> PC_EX.
REQ-007 SHALL select operand B: ALUBSrc_EX 00 -> busB_EX, 01 -> imm_EX, 10 -> 32'd4, 11 -> 32'd0.
REQ-008 SHALL decode ALUctr_EX: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB, 11 MUL; 12-15 -> result 0.
REQ-009 SHALL use B[4:0] as shift amount; SLT signed, SLTU unsigned, result 32'd1/32'd0.
REQ-010 SHALL wrap ADD/SUB modulo 2^32; MUL returns low 32 bits of unsigned product.
REQ-011 SHALL assert redirect_o when (Branch_EX and ALU result == 0) or Jump_EX, gated low while stall_o=1.
REQ-012 SHALL drive target_o = PC_EX + imm_EX (mod 2^32) regardless of redirect_o.
REQ-013 SHALL, for non-MUL ops, load EX/MEM on each negedge with ALU result, busB_EX, Rd_EX and controls (latency 1 edge).
REQ-014 SHALL run MUL as a sequential shift-add FSM with states IDLE, BUSY, DONE.
REQ-015 IDLE with ALUctr_EX=MUL: stall_o=1 combinationally; next edge latch A, B, clear 5-bit count and product, -> BUSY.
REQ-016 BUSY: stall_o=1; each edge adds (B bit[count] ? A<<count : 0) to product, count++; edge with count==31 -> DONE.
REQ-017 DONE: stall_o=0; EX/MEM captures product and the held MUL controls; next edge -> IDLE unconditionally (held MUL is not restarted).
REQ-018 SHALL hold stall_o high for exactly 33 consecutive cycles per MUL, low in DONE.
REQ-019 SHALL load EX/MEM with a bubble (MemWr, MemtoReg, RegWr = 0; data, Rd = 0) on every edge while stall_o=1.
REQ-020 Back-to-back MULs SHALL each take 34 cycles (IDLE detect through DONE); no overlap.
REQ-021 Branch_EX or Jump_EX with ALUctr_EX=MUL SHALL have redirect evaluated only in DONE.

Reset
REQ-022 On Resetn=0 at negedge: all EX/MEM outputs 0, FSM -> IDLE, count and product 0.
REQ-023 Reset mid-MUL SHALL abandon the operation; stall_o=0 from the edge after reset unless a MUL is presented in IDLE.
REQ-024 Combinational outputs SHALL follow inputs during reset; stall_o is driven from IDLE state only.

Structure
REQ-025 Shared package ex_pkg SHALL hold ALUctr codes, ALUBSrc encodings, FSM state type and constant 32'd4.
REQ-026 Multiplier FSM SHALL be sub-module mul_seq (start, A, B -> busy, done, product); ALU, mux and EX/MEM register in ex_stage.

Verification
REQ-027 ADD busA=5, imm=7, ALUBSrc=01, RegWr=1, Rd=3 -> next edge ALUout_MEM=12, Rd_MEM=3, RegWr_MEM=1.
REQ-028 SUB busA=busB=9, Branch=1, PC=0x100, imm=0x20 -> redirect_o=1, target_o=0x120; busB=8 -> redirect_o=0.
REQ-029 Jump=1, ALUASrc=1, ALUBSrc=10, PC=0x40 -> ALUout_MEM=0x44, redirect_o=1.
REQ-030 MUL 0xFFFF_FFFF x 3 -> stall_o high 33 cycles, RegWr_MEM=0 throughout, then ALUout_MEM=0xFFFF_FFFD with RegWr_MEM=1.
REQ-031 Resetn low at BUSY count=10 -> outputs 0, FSM IDLE; MUL 6x7 then -> 42.
REQ-032 SLT 0x8000_0000 vs 1 -> 1; SLTU same -> 0; SRA 0x8000_0000 by 4 -> 0xF800_0000.
